// File: rtl/counter_ctrl.sv
// Sequencing controller for the free-running counter: start/pause/stop,
// programmable prescaler and terminal count, one-shot or auto-reload.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; config writable; value cleared
// RUN   | prescaler counting, value incrementing on each event
// PAUSE | value and prescaler frozen; start resumes, stop aborts
// DONE  | one-shot reached limit; value held; config writable
module counter_ctrl #(
   parameter int WIDTH = 8,
   parameter int PW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic [PW-1:0]    cfg_prescale,
   input  logic             cfg_autoreload,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] value,
   output logic             running,
   output logic             tick,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] value_nxt;
   logic [PW-1:0]    presc, presc_nxt;
   logic [WIDTH-1:0] limit, limit_nxt;
   logic [PW-1:0]    prescale, prescale_nxt;
   logic             autoreload, autoreload_nxt;
   logic             tick_nxt, done_nxt;
   logic             cfg_open;
   logic             event_e;

   assign cfg_open = (state == S_IDLE) || (state == S_DONE);
   assign event_e  = (presc == prescale);

   always_comb begin
      state_nxt      = state;
      value_nxt      = value;
      presc_nxt      = presc;
      limit_nxt      = limit;
      prescale_nxt   = prescale;
      autoreload_nxt = autoreload;
      tick_nxt       = 1'b0;
      done_nxt       = 1'b0;

      if (cfg_open && cfg_we) begin
         limit_nxt      = cfg_limit;
         prescale_nxt   = cfg_prescale;
         autoreload_nxt = cfg_autoreload;
      end

      case (state)
         S_IDLE, S_DONE: begin
            if (start && !stop) begin
               value_nxt = '0;
               presc_nxt = '0;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_nxt = S_PAUSE;
            end else if (event_e) begin
               presc_nxt = '0;
               tick_nxt  = 1'b1;
               if (value != limit) begin
                  value_nxt = value + 1'b1;
               end else begin
                  done_nxt = 1'b1;
                  // one-shot keeps value parked at limit
                  if (autoreload) value_nxt = '0;
                  else            state_nxt = S_DONE;
               end
            end else begin
               presc_nxt = presc + 1'b1;
            end
         end
         S_PAUSE: begin
            if (stop) begin
               value_nxt = '0;
               presc_nxt = '0;
               state_nxt = S_IDLE;
            end else if (start) begin
               state_nxt = S_RUN;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         value      <= '0;
         presc      <= '0;
         limit      <= '1;
         prescale   <= '0;
         autoreload <= 1'b0;
         running    <= 1'b0;
         tick       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         value      <= value_nxt;
         presc      <= presc_nxt;
         limit      <= limit_nxt;
         prescale   <= prescale_nxt;
         autoreload <= autoreload_nxt;
         running    <= (state_nxt == S_RUN);
         tick       <= tick_nxt;
         done       <= done_nxt;
      end
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: a cycle model queues expected outputs as
// each stimulus cycle is driven; they are popped and compared after the edge.
module tb_counter_ctrl;

   localparam int WIDTH = 8;
   localparam int PW    = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic             clk;
   logic             reset;
   logic             cfg_we;
   logic [WIDTH-1:0] cfg_limit;
   logic [PW-1:0]    cfg_prescale;
   logic             cfg_autoreload;
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] value;
   logic             running;
   logic             tick;
   logic             done;

   counter_ctrl #(.WIDTH(WIDTH), .PW(PW)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_we         (cfg_we),
      .cfg_limit      (cfg_limit),
      .cfg_prescale   (cfg_prescale),
      .cfg_autoreload (cfg_autoreload),
      .start          (start),
      .stop           (stop),
      .value          (value),
      .running        (running),
      .tick           (tick),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int val;
      bit run;
      bit tk;
      bit dn;
   } exp_t;

   exp_t q_exp[$];

   int n_tests;
   int n_fail;
   int done_seen;

   int m_st, m_val, m_pre, m_lim, m_ps;
   bit m_ar, m_tick, m_done;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_val = 0; m_pre = 0;
      m_lim = (1 << WIDTH) - 1; m_ps = 0; m_ar = 1'b0;
      m_tick = 1'b0; m_done = 1'b0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.val = m_val; e.run = (m_st == M_RUN); e.tk = m_tick; e.dn = m_done;
      q_exp.push_back(e);
   endtask

   // Advance the reference by one clock edge using the inputs now driven.
   task automatic model_step();
      m_tick = 1'b0;
      m_done = 1'b0;
      if (!reset) begin
         model_reset();
         return;
      end
      if ((m_st == M_IDLE || m_st == M_DONE) && cfg_we) begin
         m_lim = cfg_limit; m_ps = cfg_prescale; m_ar = cfg_autoreload;
      end
      if (m_st == M_IDLE || m_st == M_DONE) begin
         if (start && !stop) begin m_st = M_RUN; m_val = 0; m_pre = 0; end
      end else if (m_st == M_PAUSE) begin
         if (stop) begin m_st = M_IDLE; m_val = 0; m_pre = 0; end
         else if (start) m_st = M_RUN;
      end else if (stop) begin
         m_st = M_PAUSE;
      end else if (m_pre < m_ps) begin
         m_pre++;
      end else begin
         m_pre = 0;
         m_tick = 1'b1;
         if (m_val < m_lim) m_val++;
         else begin
            m_done = 1'b1;
            if (m_ar) m_val = 0;
            else m_st = M_DONE;
         end
      end
   endtask

   task automatic compare_out();
      exp_t e;
      if (q_exp.size() == 0) begin
         check_eq("queue_underflow", 0, 1);
         return;
      end
      e = q_exp.pop_front();
      check_eq("value", int'(value), e.val);
      check_eq("running", int'(running), int'(e.run));
      check_eq("tick", int'(tick), int'(e.tk));
      check_eq("done", int'(done), int'(e.dn));
      if (done === 1'b1) done_seen++;
   endtask

   task automatic cycle(input bit s, input bit st, input bit we,
                        input int lim, input int ps, input bit ar);
      start = s; stop = st; cfg_we = we;
      cfg_limit = lim[WIDTH-1:0]; cfg_prescale = ps[PW-1:0]; cfg_autoreload = ar;
      model_step();
      push_exp();
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; done_seen = 0;
      reset = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
      cfg_limit = '0; cfg_prescale = '0; cfg_autoreload = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      push_exp();
      compare_out();
      reset = 1'b1;

      // defaults: one-shot to 255, event every edge
      done_seen = 0;
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(256);
      idle(3);
      check_eq("t1_done_count", done_seen, 1);
      check_eq("t1_hold", int'(value), 255);

      // auto-reload, limit 3, prescale 2: done every 12 cycles
      done_seen = 0;
      cycle(1'b1, 1'b0, 1'b1, 3, 2, 1'b1);
      idle(36);
      check_eq("t2_done_count", done_seen, 3);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

      // one-shot limit 9, pause at 4 for 5 cycles, resume
      done_seen = 0;
      cycle(1'b1, 1'b0, 1'b1, 9, 0, 1'b0);
      idle(4);
      check_eq("t3_pre_pause", int'(value), 4);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      idle(5);
      check_eq("t3_frozen", int'(value), 4);
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(8);
      check_eq("t3_done_count", done_seen, 1);
      check_eq("t3_final", int'(value), 9);

      // pause at 4 then abort; then limit 0 gives done every edge
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(4);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      check_eq("t4_abort_value", int'(value), 0);
      done_seen = 0;
      cycle(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      check_eq("t4_limit0_done", done_seen, 1);
      check_eq("t4_limit0_value", int'(value), 0);
      idle(2);

      // start+stop in IDLE is a no-op; cfg_we during RUN ignored
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      check_eq("t5_no_start", int'(running), 0);
      done_seen = 0;
      cycle(1'b1, 1'b0, 1'b1, 10, 0, 1'b0);
      idle(2);
      cycle(1'b0, 1'b0, 1'b1, 7, 0, 1'b0);
      idle(12);
      check_eq("t5_done_count", done_seen, 1);
      check_eq("t5_final", int'(value), 10);

      // async reset mid-RUN at value 6
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      idle(6);
      check_eq("t6_pre_reset", int'(value), 6);
      reset = 1'b0;
      #1;
      model_reset();
      push_exp();
      compare_out();
      idle(3);
      reset = 1'b1;
      idle(4);
      check_eq("t6_stays_idle", int'(running), 0);
      check_eq("t6_queue_empty", q_exp.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
